// File: rtl/cpu_pkg.sv
// Definitions shared by the fetch stage and the control decoder: fetch state
// encoding, primary opcodes and default fetch parameters.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_ERROR = 2'd3
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [31:0] DEFAULT_RESET_PC       = 32'h0000_0000;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 16;

    // Word-aligned branch displacement: sign-extended immediate times four.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge channel between the fetch stage
// (master) and instruction memory (slave).
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC selection from the resolved control signals; Jump outranks a taken
// branch, all additions wrap modulo 2^32.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] next_pc
);

    // The opcode field plays no part in target formation.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instr[31:26];

    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (Branch && Zero) begin
            next_pc = pc_plus4 + branch_offset(instr[15:0]);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch stage: holds the PC, fetches one word over the
// req/ack channel, presents it until retirement, then advances the PC.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master imem,
    output logic [31:0]  instr,
    output logic [5:0]   opcode,
    output logic         instr_valid,
    input  logic         exec_done,
    input  logic         Branch,
    input  logic         Jump,
    input  logic         Zero,
    output logic [31:0]  pc,
    output logic [31:0]  pc_plus4,
    output logic         fetch_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    fetch_state_t     state_reg;
    logic [31:0]      pc_reg;
    logic [31:0]      instr_reg;
    logic             instr_valid_reg;
    logic             imem_req_reg;
    logic             fetch_err_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [31:0]      pc_plus4_next;
    logic [31:0]      next_pc;

    assign pc_plus4_next = pc_reg + 32'd4;
    assign cnt_next      = cnt_reg + CNT_W'(1);

    next_pc_calc u_next_pc_calc (
        .pc_plus4 (pc_plus4_next),
        .instr    (instr_reg),
        .Branch   (Branch),
        .Jump     (Jump),
        .Zero     (Zero),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            instr_reg       <= '0;
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b0;
            fetch_err_reg   <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    state_reg    <= ST_FETCH;
                    imem_req_reg <= 1'b1;
                    cnt_reg      <= '0;
                end
                ST_FETCH: begin
                    // An ack arriving on the limit edge still completes the fetch.
                    if (imem.imem_ack) begin
                        instr_reg       <= imem.imem_rdata;
                        state_reg       <= ST_EXEC;
                        imem_req_reg    <= 1'b0;
                        instr_valid_reg <= 1'b1;
                        cnt_reg         <= '0;
                    end else if (TIMEOUT_CYCLES != 0 && cnt_next == CNT_LIMIT) begin
                        state_reg     <= ST_ERROR;
                        imem_req_reg  <= 1'b0;
                        fetch_err_reg <= 1'b1;
                        cnt_reg       <= cnt_next;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        pc_reg          <= next_pc;
                        state_reg       <= ST_FETCH;
                        instr_valid_reg <= 1'b0;
                        imem_req_reg    <= 1'b1;
                    end
                end
                ST_ERROR: begin
                    // Parked with pc at the faulting address until reset.
                    state_reg <= ST_ERROR;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem.imem_req  = imem_req_reg;
    assign imem.imem_addr = pc_reg;
    assign instr          = instr_reg;
    assign opcode         = instr_reg[31:26];
    assign instr_valid    = instr_valid_reg;
    assign pc             = pc_reg;
    assign pc_plus4       = pc_plus4_next;
    assign fetch_err      = fetch_err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against an instruction-level
// PC model; a second instance with a high reset PC covers upper-region jumps.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        exec_done;
    logic        Branch;
    logic        Jump;
    logic        Zero;
    logic        sel;

    int total;
    int bad;
    logic [31:0] model_pc;

    fetch_unit_if mem_a ();
    fetch_unit_if mem_b ();

    assign mem_a.imem_ack   = ack;
    assign mem_a.imem_rdata = rdata;
    assign mem_b.imem_ack   = ack;
    assign mem_b.imem_rdata = rdata;

    logic [31:0] instr_a, instr_b, pc_a, pc_b, pc4_a, pc4_b;
    logic [5:0]  opcode_a, opcode_b;
    logic        valid_a, valid_b, err_a, err_b;

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk (clk), .rst (rst), .imem (mem_a),
        .instr (instr_a), .opcode (opcode_a), .instr_valid (valid_a),
        .exec_done (exec_done), .Branch (Branch), .Jump (Jump), .Zero (Zero),
        .pc (pc_a), .pc_plus4 (pc4_a), .fetch_err (err_a)
    );

    fetch_unit #(.RESET_PC(32'h8000_0000), .TIMEOUT_CYCLES(16)) dut_hi (
        .clk (clk), .rst (rst), .imem (mem_b),
        .instr (instr_b), .opcode (opcode_b), .instr_valid (valid_b),
        .exec_done (exec_done), .Branch (Branch), .Jump (Jump), .Zero (Zero),
        .pc (pc_b), .pc_plus4 (pc4_b), .fetch_err (err_b)
    );

    wire [31:0] o_pc     = sel ? pc_b : pc_a;
    wire [31:0] o_pc4    = sel ? pc4_b : pc4_a;
    wire [31:0] o_instr  = sel ? instr_b : instr_a;
    wire [5:0]  o_opcode = sel ? opcode_b : opcode_a;
    wire        o_valid  = sel ? valid_b : valid_a;
    wire        o_err    = sel ? err_b : err_a;
    wire        o_req    = sel ? mem_b.imem_req : mem_a.imem_req;
    wire [31:0] o_addr   = sel ? mem_b.imem_addr : mem_a.imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural next-PC rule, written from the ISA definition.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic b, input logic j, input logic z);
        logic [31:0]        seq;
        logic signed [15:0] imm;
        int                 off;
        seq = cur + 32'd4;
        if (j) return (seq & 32'hF000_0000) + (32'(word[25:0]) * 32'd4);
        if (b && z) begin
            imm = word[15:0];
            off = imm;
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    task automatic do_reset(input logic [31:0] rpc);
        rst = 1'b0; ack = 1'b0; exec_done = 1'b0;
        Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
        #1;
        check("rst_pc", o_pc, rpc);
        check("rst_req", 32'(o_req), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_instr", o_instr, 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        model_pc = rpc;
        check("first_fetch_req", 32'(o_req), 32'd1);
    endtask

    task automatic run_instr(input logic [31:0] word, input int lat, input int dwait,
                             input logic b, input logic j, input logic z);
        logic [31:0] from_pc;
        from_pc = model_pc;
        check("fetch_req", 32'(o_req), 32'd1);
        check("fetch_addr", o_addr, model_pc);
        check("fetch_valid", 32'(o_valid), 32'd0);
        for (int i = 0; i < lat; i++) begin
            ack = 1'b0; exec_done = 1'($urandom); rdata = $urandom;
            step();
            check("wait_addr", o_addr, model_pc);
            check("wait_req", 32'(o_req), 32'd1);
        end
        ack = 1'b1; rdata = word; exec_done = 1'($urandom);
        step();
        ack = 1'b0; exec_done = 1'b0; rdata = $urandom;
        check("exec_valid", 32'(o_valid), 32'd1);
        check("exec_instr", o_instr, word);
        check("exec_opcode", 32'(o_opcode), 32'(word[31:26]));
        check("exec_req", 32'(o_req), 32'd0);
        check("exec_pc", o_pc, model_pc);
        check("exec_pc_plus4", o_pc4, model_pc + 32'd4);
        for (int i = 0; i < dwait; i++) begin
            ack = 1'($urandom); Branch = 1'($urandom); Jump = 1'($urandom);
            step();
            check("exec_hold_valid", 32'(o_valid), 32'd1);
            check("exec_hold_instr", o_instr, word);
        end
        ack = 1'b0; exec_done = 1'b1; Branch = b; Jump = j; Zero = z;
        step();
        exec_done = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
        model_pc = ref_next(model_pc, word, b, j, z);
        check("next_pc", o_pc, model_pc);
        check("next_addr", o_addr, model_pc);
        check("refetch_valid", 32'(o_valid), 32'd0);
        check("refetch_req", 32'(o_req), 32'd1);
        $display("instr pc=%08h word=%08h lat=%0d b=%0b j=%0b z=%0b next=%08h",
                 from_pc, word, lat, b, j, z, o_pc);
    endtask

    initial begin
        logic [31:0] toff;
        logic [31:0] word;
        logic [31:0] frozen;
        total = 0; bad = 0; sel = 1'b0; rdata = '0;

        do_reset(32'h0000_0000);
        check("reset_addr", o_addr, 32'h0000_0000);
        run_instr(32'h2008_0005, 1, 0, 1'b0, 1'b0, 1'b0);
        check("addi_pc", o_pc, 32'h0000_0004);

        // Walk to 0x10 and exercise beq taken / not taken.
        for (int k = 0; k < 3; k++) run_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h1000_FFFE, 2, 1, 1'b1, 1'b0, 1'b1);
        check("beq_taken_pc", o_pc, 32'h0000_000C);
        run_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h1000_FFFE, 1, 0, 1'b1, 1'b0, 1'b0);
        check("beq_not_taken_pc", o_pc, 32'h0000_0014);

        // Branch to the top word, then wrap to zero.
        toff = (32'hFFFF_FFFC - (model_pc + 32'd4)) >> 2;
        word = {16'h1000, toff[15:0]};
        run_instr(word, 0, 0, 1'b1, 1'b0, 1'b1);
        check("top_pc", o_pc, 32'hFFFF_FFFC);
        run_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0);
        check("wrap_pc", o_pc, 32'h0000_0000);

        // Zero-wait memory with exec_done held: two clocks per instruction.
        ack = 1'b1; exec_done = 1'b1; rdata = 32'h2008_0005;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k % 2 == 1) model_pc = model_pc + 32'd4;
            check("toggle_valid", 32'(o_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("toggle_pc", o_pc, model_pc);
        end
        ack = 1'b0; exec_done = 1'b0;

        for (int k = 0; k < 20; k++)
            run_instr($urandom, $urandom_range(0, 4), $urandom_range(0, 2),
                      1'($urandom), 1'($urandom), 1'($urandom));
        // Ack on the edge the timeout counter would reach its limit.
        run_instr($urandom, 15, 0, 1'b0, 1'b0, 1'b0);

        // Fetch timeout.
        frozen = model_pc;
        for (int k = 0; k < 15; k++) begin
            ack = 1'b0;
            step();
            check("pre_timeout_err", 32'(o_err), 32'd0);
            check("pre_timeout_req", 32'(o_req), 32'd1);
        end
        step();
        check("timeout_err", 32'(o_err), 32'd1);
        check("timeout_req", 32'(o_req), 32'd0);
        check("timeout_valid", 32'(o_valid), 32'd0);
        check("timeout_pc", o_pc, frozen);
        ack = 1'b1; exec_done = 1'b1; rdata = 32'h2008_0005;
        for (int k = 0; k < 3; k++) begin
            step();
            check("sticky_err", 32'(o_err), 32'd1);
            check("sticky_valid", 32'(o_valid), 32'd0);
            check("sticky_req", 32'(o_req), 32'd0);
            check("sticky_pc", o_pc, frozen);
        end
        ack = 1'b0; exec_done = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("err_cleared", 32'(o_err), 32'd0);
        check("err_reset_pc", o_pc, 32'h0000_0000);
        do_reset(32'h0000_0000);

        // Asynchronous reset between edges while in EXEC.
        run_instr(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b0);
        ack = 1'b1; rdata = 32'h8C08_0004;
        step();
        ack = 1'b0;
        check("pre_areset_valid", 32'(o_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("areset_valid", 32'(o_valid), 32'd0);
        check("areset_req", 32'(o_req), 32'd0);
        check("areset_pc", o_pc, 32'h0000_0000);
        check("areset_instr", o_instr, 32'd0);
        check("areset_opcode", 32'(o_opcode), 32'd0);
        ack = 1'b1; exec_done = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        ack = 1'b0; exec_done = 1'b0;
        check("idle_stray_instr", o_instr, 32'd0);
        check("idle_stray_valid", 32'(o_valid), 32'd0);
        check("idle_stray_req", 32'(o_req), 32'd1);
        check("idle_stray_pc", o_pc, 32'h0000_0000);
        model_pc = 32'h0000_0000;
        run_instr(32'hAC08_0008, 1, 0, 1'b0, 1'b0, 1'b0);

        // Upper-region jumps on the high-reset instance.
        sel = 1'b1;
        do_reset(32'h8000_0000);
        run_instr(32'h0800_0040, 1, 0, 1'b0, 1'b1, 1'b0);
        check("jump_pc", o_pc, 32'h8000_0100);
        run_instr(32'h0800_0040, 0, 1, 1'b1, 1'b1, 1'b1);
        check("jump_priority_pc", o_pc, 32'h8000_0100);
        for (int k = 0; k < 10; k++)
            run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 1),
                      1'($urandom), 1'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
